// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - instruction/data port bundle between core and sram_responder
interface sram_responder_if;
   logic        inst_en;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        data_en;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;

   modport master (
      output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
      input  inst_rdata, data_rdata
   );

   modport slave (
      input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
      output inst_rdata, data_rdata
   );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - 1-cycle SRAM responder with clear sequencer; SRAM_WRITE_FIRST_EN selects write-first collisions
module sram_responder #(
   parameter int ADDR_W = 10
) (
   input  logic          clk,
   input  logic          rst,
   sram_responder_if.slave bus,
   output logic          init_done,
   output logic          err_oor,
   output logic [31:0]   rd_cnt,
   output logic [31:0]   wr_cnt
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   clr_ptr;
   logic [31:0]         mem [DEPTH];

   logic [ADDR_W-1:0]   inst_idx;
   logic [ADDR_W-1:0]   data_idx;
   logic                inst_oor;
   logic                data_oor;
   logic                data_wr;
   logic [31:0]         data_old;
   logic [31:0]         data_merged;
   logic [31:0]         inst_val;
   logic [31:0]         data_val;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_widx;
   logic [31:0]         mem_wval;
   logic                unused_addr_lsbs;

   // byte-offset bits never select anything; the word index drops them
   assign unused_addr_lsbs = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

   // decode addresses, merge write bytes and pick the values each port returns
   always_comb begin
      inst_idx    = bus.inst_addr[ADDR_W+1:2];
      data_idx    = bus.data_addr[ADDR_W+1:2];
      inst_oor    = |bus.inst_addr[31:ADDR_W+2];
      data_oor    = |bus.data_addr[31:ADDR_W+2];
      data_wr     = (state == READY) && bus.data_en && (bus.data_wen != 4'b0000) && !data_oor;
      data_old    = mem[data_idx];
      data_merged = data_old;
      for (int b = 0; b < 4; b++) begin
         if (bus.data_wen[b]) data_merged[8*b +: 8] = bus.data_wdata[8*b +: 8];
      end
`ifdef SRAM_WRITE_FIRST_EN
      inst_val = (data_wr && (inst_idx == data_idx)) ? data_merged : mem[inst_idx];
      data_val = data_wr ? data_merged : data_old;
`else
      inst_val = mem[inst_idx];
      data_val = data_old;
`endif
      if (state == CLEAR) begin
         mem_we   = 1'b1;
         mem_widx = clr_ptr;
         mem_wval = 32'd0;
      end else begin
         mem_we   = data_wr;
         mem_widx = data_idx;
         mem_wval = data_merged;
      end
   end

   // single write port shared by the clear sequencer and data writes
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_widx] <= mem_wval;
   end

   // clear/ready sequencer with registered read data, error flag and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= CLEAR;
         clr_ptr         <= '0;
         init_done       <= 1'b0;
         bus.inst_rdata  <= 32'd0;
         bus.data_rdata  <= 32'd0;
         err_oor         <= 1'b0;
         rd_cnt          <= 32'd0;
         wr_cnt          <= 32'd0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (&clr_ptr) begin
                  state     <= READY;
                  init_done <= 1'b1;
               end
            end
            READY: begin
               if (bus.inst_en) bus.inst_rdata <= inst_oor ? 32'd0 : inst_val;
               if (bus.data_en) begin
                  bus.data_rdata <= data_oor ? 32'd0 : data_val;
                  if (!data_oor) begin
                     if (bus.data_wen == 4'b0000) rd_cnt <= rd_cnt + 32'd1;
                     else                         wr_cnt <= wr_cnt + 32'd1;
                  end
               end
               if ((bus.inst_en && inst_oor) || (bus.data_en && data_oor)) err_oor <= 1'b1;
            end
            default: state <= CLEAR;
         endcase
      end
   end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synchronous SRAM-like responder serving the core's instruction fetch port and data port: 1-cycle read latency, byte-enable writes.
- Sits on the far side of the core's inst_en/pc and mem_en/mem_wen/mem_addr/mem_wdata interfaces.
- Replaces ad-hoc BRAM wrappers in simulation and FPGA tops.
- Adds a post-reset clear sequencer, an out-of-range error flag and access counters for the bench.

Parameters:
ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W words of 32 bits.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
init_done  output  1  high once the memory clear completes
inst_en  input  1  instruction read request
inst_addr  input  32  instruction byte address
inst_rdata  output  32  instruction read data, 1 cycle after the request
data_en  input  1  data access request
data_wen  input  4  byte write enables; 0 means read; bit i writes byte i (bits 8i+7:8i)
data_addr  input  32  data byte address
data_wdata  input  32  data write data
data_rdata  output  32  data read data, 1 cycle after the request
err_oor  output  1  sticky out-of-range access flag
rd_cnt  output  32  count of completed data reads
wr_cnt  output  32  count of completed data writes

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset values: init_done=0, inst_rdata=0, data_rdata=0, err_oor=0, rd_cnt=0, wr_cnt=0; FSM enters CLEAR with clr_ptr=0. Memory array is not reset directly.
- Word index = addr[ADDR_W+1:2]; addr[1:0] is ignored.
- Out of range when addr[31:ADDR_W+2] != 0.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clr_ptr], then clr_ptr++.
  - After writing index DEPTH-1, go to READY.
  - init_done rises on the DEPTH-th edge after rst deasserts.
  - All requests are ignored: rdata outputs hold 0, counters and err_oor are unchanged.
- FSM READY:
  - Stays in READY until rst.
  - rst at any point, including mid-clear, returns to CLEAR with clr_ptr=0 and a full restart.
- Instruction port:
  - inst_en=1 → inst_rdata = mem[idx] on the next edge.
  - inst_en=0 → inst_rdata holds its value.
- Data read (data_en=1, data_wen=0):
  - data_rdata = mem[idx] on the next edge.
  - rd_cnt++.
- Data write (data_en=1, data_wen!=0):
  - Only the enabled bytes of mem[idx] are updated.
  - data_rdata is loaded with the pre-write word.
  - wr_cnt++.
- data_en=0 → data_rdata holds its value.
- Out-of-range access on either port (when that port's enable is high):
  - The corresponding rdata loads 0 and no write occurs.
  - err_oor is set and stays 1 until rst.
  - Counters do not increment.
- Simultaneous inst read and data write to the same word: read-first, so inst_rdata returns the old word (see optional feature).
- Counters wrap from 0xFFFFFFFF to 0.
- Both ports are serviced every cycle; there is no back-pressure and no stall output.

Optional Feature:
- Macro: SRAM_WRITE_FIRST_EN.
- Defined: any read that coincides with a data write to the same in-range word returns the byte-merged new word. This applies to inst_rdata and to data_rdata on the writing access itself (enabled bytes from data_wdata, others from old mem).
- Undefined: read-first; the old word is returned, as above.

Test Plan:
1. Clear sequence (ADDR_W=4): pulse rst for 1 cycle → init_done=0 for exactly 16 cycles, then 1; a READY data read of 0x0000003C → data_rdata=0x00000000 next cycle, rd_cnt=1.
2. Full-word write/read: write wen=4'b1111, addr 0x10, data 0xDEADBEEF; read 0x10 next cycle → data_rdata=0xDEADBEEF one cycle later; wr_cnt=1, rd_cnt=1.
3. Byte write: write wen=4'b0010, addr 0x12, data 0x0000AA00 onto 0xDEADBEEF; read 0x10 → 0xDEADAAEF; an inst_en read of 0x10 → inst_rdata=0xDEADAAEF.
4. Collision: mem[0x20]=0x11111111; same cycle inst_en read 0x20 and data write 0x22222222 to 0x20 → inst_rdata=0x11111111 without the macro, 0x22222222 with SRAM_WRITE_FIRST_EN; a later read returns 0x22222222 in both builds.
5. Out of range (ADDR_W=4): write wen=4'b1111 to 0x00010000 → err_oor=1 next cycle, data_rdata=0, wr_cnt unchanged, mem[0] still 0; err_oor stays 1 until rst.
6. Reset mid-clear: assert rst on clear cycle 5 → init_done stays 0 and the clear restarts; init_done=1 exactly 16 cycles after rst deasserts; a write issued while init_done=0 leaves wr_cnt=0 and mem unchanged.
